// File: rtl/pc_call_stack.sv
// Program counter with increment/load, optional signed relative branch, and call/return
// through an internal return-address stack with sticky overflow/underflow flags.
// Optional feature macro: PC_CALL_STACK_REL_EN enables the pc_rel relative branch.
module pc_call_stack #(
  parameter int ADDR_WIDTH   = 14,
  parameter int STACK_DEPTH  = 8,
  parameter int RESET_VECTOR = 0,
  localparam int LW = $clog2(STACK_DEPTH + 1),
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pc_en,
  input  logic                  pc_ld,
  input  logic                  pc_rel,
  input  logic                  pc_call,
  input  logic                  pc_ret,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  stack_empty,
  output logic                  stack_full,
  output logic [1:0]            stack_err,
  output logic [LW-1:0]         stack_level
);

  logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_q, pc_next, pc_plus1;
  logic [LW-1:0]         level_q, level_next;
  logic [1:0]            err_q, err_next;
  logic                  push;
  logic [IW-1:0]         push_idx, top_idx;

  assign pc_plus1    = pc_q + ADDR_WIDTH'(1);
  assign stack_empty = (level_q == '0);
  assign stack_full  = (level_q == LW'(STACK_DEPTH));
  // Only meaningful when not empty / not full; the guards below keep them in range.
  assign push_idx    = IW'(level_q);
  assign top_idx     = IW'(level_q - LW'(1));

`ifndef PC_CALL_STACK_REL_EN
  logic unused_rel;
  assign unused_rel = pc_rel;
`endif

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    pc_next    = pc_q;
    level_next = level_q;
    err_next   = err_q;
    push       = 1'b0;
    if (pc_en) begin
      if (pc_ret) begin
        if (stack_empty) begin
          pc_next     = pc_plus1;
          err_next[1] = 1'b1;
        end else begin
          pc_next    = stack_mem[top_idx];
          level_next = level_q - LW'(1);
        end
      end else if (pc_call) begin
        pc_next = pc_in;
        if (stack_full) begin
          err_next[0] = 1'b1;
        end else begin
          push       = 1'b1;
          level_next = level_q + LW'(1);
        end
      end else if (pc_ld) begin
        pc_next = pc_in;
`ifdef PC_CALL_STACK_REL_EN
      end else if (pc_rel) begin
        // Modular add is identical to signed add truncated to ADDR_WIDTH.
        pc_next = pc_q + pc_in;
`endif
      end else begin
        pc_next = pc_plus1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= ADDR_WIDTH'(RESET_VECTOR);
      level_q <= '0;
      err_q   <= 2'b00;
    end else begin
      pc_q    <= pc_next;
      level_q <= level_next;
      err_q   <= err_next;
    end
  end

  // NOTE: the stack array is deliberately not reset; level alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      stack_mem[push_idx] <= pc_plus1;
    end
  end

  assign pc_out      = pc_q;
  assign stack_err   = err_q;
  assign stack_level = level_q;

endmodule

// File: tb/tb_pc_call_stack.sv
// Scoreboard bench for pc_call_stack: directed plan plus random traffic against a queue-based
// reference model; a monitor compares DUT state one cycle after each issued command.
module tb_pc_call_stack;
  localparam int AW = 14;
  localparam int D  = 8;
  localparam int RV = 0;
  localparam int M  = 1 << AW;
  localparam int LW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0, pc_en = 1'b0, pc_ld = 1'b0, pc_rel = 1'b0;
  logic          pc_call = 1'b0, pc_ret = 1'b0;
  logic [AW-1:0] pc_in = '0;
  logic [AW-1:0] pc_out;
  logic          stack_empty, stack_full;
  logic [1:0]    stack_err;
  logic [LW-1:0] stack_level;

  pc_call_stack #(.ADDR_WIDTH(AW), .STACK_DEPTH(D), .RESET_VECTOR(RV)) dut (
    .clk(clk), .reset(reset), .pc_en(pc_en), .pc_ld(pc_ld), .pc_rel(pc_rel),
    .pc_call(pc_call), .pc_ret(pc_ret), .pc_in(pc_in), .pc_out(pc_out),
    .stack_empty(stack_empty), .stack_full(stack_full), .stack_err(stack_err),
    .stack_level(stack_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pc;
    int level;
    int err;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state
  int m_pc  = RV;
  int m_err = 0;
  int m_stk[$];

`ifdef PC_CALL_STACK_REL_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wrap(input int x);
    return ((x % M) + M) % M;
  endfunction

  function automatic int to_signed(input int x);
    return (x >= M / 2) ? x - M : x;
  endfunction

  task automatic model(input bit rst, input bit en, input bit ret, input bit call,
                       input bit ld, input bit rel, input int in);
    if (rst) begin
      m_pc  = RV;
      m_err = 0;
      m_stk.delete();
    end else if (en) begin
      if (ret) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin
          m_pc  = wrap(m_pc + 1);
          m_err = m_err | 2;
        end
      end else if (call) begin
        if (m_stk.size() < D) m_stk.push_back(wrap(m_pc + 1));
        else m_err = m_err | 1;
        m_pc = in;
      end else if (ld) m_pc = in;
      else if (rel && REL_EN) m_pc = wrap(m_pc + to_signed(in));
      else m_pc = wrap(m_pc + 1);
    end
    exp_q.push_back('{pc: m_pc, level: m_stk.size(), err: m_err});
  endtask

  // Drive one cycle of stimulus and record its expected outcome.
  task automatic step(input bit rst, input bit en, input bit ret, input bit call,
                      input bit ld, input bit rel, input int in);
    @(negedge clk);
    reset = rst; pc_en = en; pc_ret = ret; pc_call = call; pc_ld = ld; pc_rel = rel;
    pc_in = AW'(in);
    model(rst, en, ret, call, ld, rel, in);
  endtask

  // Monitor: DUT state after each posedge corresponds to the oldest pending command.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("pc_out", int'(pc_out), e.pc);
      check("stack_level", int'(stack_level), e.level);
      check("stack_empty", int'(stack_empty), int'(e.level == 0));
      check("stack_full", int'(stack_full), int'(e.level == D));
      check("stack_err", int'(stack_err), e.err);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    // Reset then idle increments
    step(1, 0, 0, 0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0, 0, 0);
    // Relative branch by -4 from 0x10
    step(0, 1, 0, 0, 1, 0, 'h0010);
    step(0, 1, 0, 0, 0, 1, 'h3FFC);
    // Nested call / return
    step(0, 1, 0, 0, 1, 0, 'h0020);
    step(0, 1, 0, 1, 0, 0, 'h0100);
    step(0, 1, 0, 1, 0, 0, 'h0200);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    // Overflow: nine calls then eight returns
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) step(0, 1, 0, 1, 0, 0, 'h1000 + i * 'h10);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 0, 0, 0);
    // Underflow with PC wrap
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0, 'h3FFF);
    step(0, 1, 1, 0, 0, 0, 0);
    // Disabled strobes hold everything
    step(0, 0, 1, 1, 1, 1, 'h1234);
    step(0, 0, 0, 1, 0, 0, 'h0555);
    step(0, 0, 0, 0, 0, 0, 0);
    // Priority: ret wins over call and ld
    step(0, 1, 0, 1, 0, 0, 'h0050);
    step(0, 1, 1, 1, 1, 0, 'h0777);
    // Reset beats call
    step(0, 1, 0, 1, 0, 0, 'h0060);
    step(1, 1, 0, 1, 0, 0, 'h0070);
    step(0, 1, 0, 0, 0, 0, 0);
    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      step(r < 1, $urandom_range(0, 9) < 8, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, M - 1));
    end
    // Drain the scoreboard with a bounded wait
    begin
      int budget = 10;
      while (exp_q.size() > 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      check("scoreboard_drained", exp_q.size(), 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_call_stack.md
# pc_call_stack

Parametrised program-counter unit that replaces the plain increment/load counter in the datapath. It adds signed PC-relative branching, call/return through an internal return-address stack of configurable depth, and sticky overflow/underflow error reporting. It sits between the FSM (control strobes), the register mux A output (target/offset) and the memory port-A address mux (`pc_out`).

## Interface
Parameters:
- `ADDR_WIDTH`, 14, width of PC, targets, offsets and stack entries
- `STACK_DEPTH`, 8, number of return-address entries (≥2)
- `RESET_VECTOR`, 0, PC value loaded on reset

Ports:
- `clk`  in  1  system clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high; overrides every other input
- `pc_en`  in  1  advance enable; when low, all state holds and strobes are ignored
- `pc_ld`  in  1  absolute jump to `pc_in`
- `pc_rel`  in  1  relative branch by signed `pc_in`
- `pc_call`  in  1  push return address, jump to `pc_in`
- `pc_ret`  in  1  pop return address into PC
- `pc_in`  in  ADDR_WIDTH  target (ld/call) or two's-complement offset (rel)
- `pc_out`  out  ADDR_WIDTH  current PC, registered
- `stack_empty`  out  1  stack holds 0 entries
- `stack_full`  out  1  stack holds STACK_DEPTH entries
- `stack_err`  out  2  sticky: bit0 overflow, bit1 underflow
- `stack_level`  out  $clog2(STACK_DEPTH+1)  entry count

## Operation
- Reset: `pc_out`=RESET_VECTOR, level=0, `stack_err`=2'b00; stack contents need not be cleared.
- With `pc_en`=1, exactly one action per cycle, priority `pc_ret` > `pc_call` > `pc_ld` > `pc_rel` > increment.
- Increment: `pc_out` ← `pc_out`+1, modulo 2^ADDR_WIDTH (wraps all-ones → 0).
- Load: `pc_out` ← `pc_in`.
- Relative: `pc_out` ← `pc_out` + `pc_in` (signed), truncated to ADDR_WIDTH. Offset 0 holds PC (spin loop).
- Call: stack[level] ← `pc_out`+1 (wrapped), level+1, `pc_out` ← `pc_in`.
  - Call when full: jump still taken, push dropped, level unchanged, `stack_err[0]` set.
- Return: `pc_out` ← stack[level-1], level-1.
  - Return when empty: behaves as increment, `stack_err[1]` set.
- `stack_err` bits clear only on reset.
- `pc_en`=0: `pc_out`, level, stack and errors hold regardless of strobes.
- Stack is LIFO; no wrap-around of the stack pointer under any condition.

## Timing
- Single clock domain. All updates take effect on the posedge where `pc_en`=1; `pc_out` shows the new value the next cycle (1-cycle latency).
- `stack_empty`, `stack_full` and `stack_level` are derived from the registered level and track it in the same cycle.
- The popped address is available on `pc_out` the cycle after `pc_ret`. Back-to-back call/ret on consecutive enabled cycles is supported at full rate with no bubbles.
- `reset` asserted mid-sequence (e.g. with `pc_call`) wins: the result is the reset state and no push occurs.
- Simultaneous strobes are resolved by priority only. The losing strobes have no side effects.

## Configuration
- `PC_CALL_STACK_REL_EN`
  - Defined: `pc_rel` is honoured as described above.
  - Undefined: `pc_rel` is ignored. A cycle with only `pc_rel` set (and `pc_en`=1) performs an increment; the adder is not synthesised.
- Call/return and all other behaviour are identical in both builds.

## Test plan
- Reset then 3 enabled idle cycles → `pc_out` 0,1,2,3; `stack_empty`=1, `stack_err`=0.
- PC=0x0010, `pc_rel` with `pc_in`=0x3FFC (−4, ADDR_WIDTH=14) → PC=0x000C. With the macro undefined → 0x0011.
- PC=0x0020, `pc_call` `pc_in`=0x0100; next cycle `pc_call` `pc_in`=0x0200; then two `pc_ret` → PC sequence 0x0100, 0x0200, 0x0101, 0x0021; level 1,2,1,0.
- STACK_DEPTH=8: 9 consecutive calls → `stack_full`=1 after the 8th, `stack_err`=01 after the 9th, PC = 9th target; 8 returns then recover entries 1–8 in LIFO order.
- `pc_ret` on empty stack at PC=0x3FFF → PC=0x0000, `stack_err`=10. Strobes with `pc_en`=0 → no change.
- `pc_ret`+`pc_call`+`pc_ld` asserted together with level=1 → pop only. `reset` asserted alongside `pc_call` → PC=RESET_VECTOR, level=0.
